prog_loader: RTL

- Boot-time program loader upstream of the 8-bit program/data memory.
- Accepts a framed byte stream over a valid/ready handshake, writes the payload into consecutive memory locations and verifies a checksum.
- Holds the processor in reset until a good image is loaded.
- The top level muxes the loader's write port onto the memory's we/address/data bus while cpu_reset is high.

---
 rtl/prog_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream in, memory writes out.
// Holds the processor in reset until a checksum-verified image is loaded.
module prog_loader #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter logic [AW-1:0] START_ADDR = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          cpu_reset,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] count
);

  typedef enum logic [2:0] {
    LEN, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] len, len_n;
  logic [AW-1:0] idx, idx_n;
  logic [AW-1:0] addr_n, count_n;
  logic [DW-1:0] sum, sum_n, data_n;
  logic [DW-1:0] total;
  logic          xfer, last;

  assign xfer  = in_valid & in_ready;
  assign total = sum + in_data;
  // len of zero encodes a full 2^AW byte payload
  assign last  = ({1'b0, idx} + 1'b1) == {len == '0, len};

  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    sum_n   = sum;
    addr_n  = mem_addr;
    data_n  = mem_data;
    count_n = count;
    unique case (state)
      LEN: begin
        if (xfer) begin
          len_n   = AW'(in_data);
          idx_n   = '0;
          sum_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          data_n  = in_data;
          addr_n  = START_ADDR + idx;
          sum_n   = total;
          state_n = WRITE;
        end
      end
      WRITE: begin
        count_n = count + 1'b1;
        idx_n   = idx + 1'b1;
        state_n = last ? CSUM : DATA;
      end
      CSUM: begin
        if (xfer) state_n = (total == '0) ? DONE : ERR;
      end
      DONE, ERR: ;
      default: state_n = LEN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LEN;
      len       <= '0;
      idx       <= '0;
      sum       <= '0;
      mem_addr  <= START_ADDR;
      mem_data  <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      idx       <= idx_n;
      sum       <= sum_n;
      mem_addr  <= addr_n;
      mem_data  <= data_n;
      count     <= count_n;
      in_ready  <= (state_n == LEN) || (state_n == DATA)
                || (state_n == CSUM);
      mem_we    <= state_n == WRITE;
      cpu_reset <= state_n != DONE;
      done      <= state_n == DONE;
      error     <= state_n == ERR;
    end
  end

endmodule
